// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: debounces scanner codes into presses and builds a multi-digit entry
// handed off over valid/ready. Optional inactivity timeout when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry_ctrl #(
  parameter int DIGITS         = 4,
  parameter int STABLE_CYCLES  = 4000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic [3:0]                   key_code,
  input  logic                         entry_ready,
  output logic                         entry_valid,
  output logic [4*DIGITS-1:0]          entry_data,
  output logic [$clog2(DIGITS+1)-1:0]  entry_len,
  output logic [4*DIGITS-1:0]          display,
  output logic [$clog2(DIGITS+1)-1:0]  disp_len,
  output logic                         overflow,
  output logic                         timeout
);

  localparam int DW = 4 * DIGITS;
  localparam int LW = $clog2(DIGITS + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic       {WAIT_PRESS, WAIT_RELEASE} qual_t;
  typedef enum logic [1:0] {IDLE, ENTRY, SEND}         entry_t;

  logic [3:0]    k_q;
  logic [SW-1:0] stab_cnt;
  logic          stable, is_none, press;
  qual_t         qual_q, qual_d;

  // Counter tracks how many edges k_q has held its current value, saturating at STABLE_CYCLES.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      k_q      <= 4'hF;
      stab_cnt <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of k_q.
      k_q <= key_code;
      if (key_code != k_q)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(STABLE_CYCLES))
        stab_cnt <= stab_cnt + SW'(1);
    end
  end

  assign stable  = (stab_cnt == SW'(STABLE_CYCLES));
  assign is_none = (k_q == 4'hD) || (k_q == 4'hE) || (k_q == 4'hF);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) qual_q <= WAIT_PRESS;
    else            qual_q <= qual_d;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    qual_d = qual_q;
    case (qual_q)
      WAIT_PRESS:   if (stable && !is_none) qual_d = WAIT_RELEASE;
      WAIT_RELEASE: if (stable && is_none)  qual_d = WAIT_PRESS;
      default:      qual_d = WAIT_PRESS;
    endcase
  end

  always_comb begin
    press = (qual_q == WAIT_PRESS) && stable && !is_none;
  end

  logic       is_digit, is_clear, is_enter;
  logic [3:0] digit;

  always_comb begin
    is_digit = (k_q >= 4'h1 && k_q <= 4'h9) || (k_q == 4'hB);
    digit    = (k_q == 4'hB) ? 4'h0 : k_q;
    is_clear = (k_q == 4'hA);
    is_enter = (k_q == 4'hC);
  end

  entry_t        state_q, state_d;
  logic [DW-1:0] buf_q, buf_d, edata_d;
  logic [LW-1:0] len_q, len_d, elen_d;
  logic          valid_d, ovf_d, to_d, timeout_hit;

`ifdef KEYPAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;

  // Held at zero outside ENTRY, so it restarts on every entry into ENTRY.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                    idle_cnt <= '0;
    else if (state_q != ENTRY || press) idle_cnt <= '0;
    else                               idle_cnt <= idle_cnt + TW'(1);
  end

  assign timeout_hit = (state_q == ENTRY) && !press && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (press && is_digit) state_d = ENTRY;
      ENTRY: begin
        if (press && is_clear)      state_d = IDLE;
        else if (press && is_enter) state_d = SEND;
        else if (timeout_hit)       state_d = IDLE;
      end
      SEND:    if (entry_valid && entry_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    len_d   = len_q;
    edata_d = entry_data;
    elen_d  = entry_len;
    valid_d = entry_valid;
    ovf_d   = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      IDLE: if (press && is_digit) begin
        buf_d = DW'(digit);
        len_d = LW'(1);
      end
      ENTRY: begin
        if (press && is_digit) begin
          if (len_q < LW'(DIGITS)) begin
            buf_d = (buf_q << 4) | DW'(digit);
            len_d = len_q + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end else if (press && is_clear) begin
          buf_d = '0;
          len_d = '0;
        end else if (press && is_enter) begin
          edata_d = buf_q;
          elen_d  = len_q;
          valid_d = 1'b1;
        end else if (timeout_hit) begin
          buf_d = '0;
          len_d = '0;
          to_d  = 1'b1;
        end
      end
      SEND: if (entry_valid && entry_ready) begin
        valid_d = 1'b0;
        buf_d   = '0;
        len_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      buf_q       <= '0;
      len_q       <= '0;
      entry_data  <= '0;
      entry_len   <= '0;
      entry_valid <= 1'b0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      len_q       <= len_d;
      entry_data  <= edata_d;
      entry_len   <= elen_d;
      entry_valid <= valid_d;
      overflow    <= ovf_d;
      timeout     <= to_d;
    end
  end

  assign display  = buf_q;
  assign disp_len = len_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; completed entries are checked through an expected-entry queue.
module tb_keypad_entry_ctrl;

  localparam int S  = 4;
  localparam int D  = 4;
  localparam int T  = 100;
  localparam int LW = $clog2(D + 1);

  logic            sys_clk = 1'b0;
  logic            sys_rst_n = 1'b0;
  logic [3:0]      key_code = 4'hF;
  logic            entry_ready = 1'b0;
  logic            entry_valid;
  logic [4*D-1:0]  entry_data;
  logic [LW-1:0]   entry_len;
  logic [4*D-1:0]  display;
  logic [LW-1:0]   disp_len;
  logic            overflow;
  logic            timeout;

  keypad_entry_ctrl #(.DIGITS(D), .STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_code    (key_code),
    .entry_ready (entry_ready),
    .entry_valid (entry_valid),
    .entry_data  (entry_data),
    .entry_len   (entry_len),
    .display     (display),
    .disp_len    (disp_len),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [4*D-1:0] data;
    logic [LW-1:0]  len;
  } entry_t;

  entry_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int ovf_cnt = 0;
  int to_cnt = 0;
  int valid_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transfers complete on the posedge following a negedge where valid && ready.
  always @(negedge sys_clk) begin
    if (overflow)    ovf_cnt++;
    if (timeout)     to_cnt++;
    if (entry_valid) valid_cyc++;
    if (entry_valid && entry_ready) begin
      check("xfer_expected", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        entry_t e;
        e = exp_q.pop_front();
        check("xfer_data", 32'(entry_data), 32'(e.data));
        check("xfer_len",  32'(entry_len),  32'(e.len));
      end
    end
  end

  task automatic key(input logic [3:0] c, input int hold);
    @(negedge sys_clk) key_code = c;
    repeat (hold) @(negedge sys_clk);
    key_code = 4'hF;
    repeat (S + 3) @(negedge sys_clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge sys_clk);
    #1 entry_ready = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ov0, vc0, to0;
    entry_t e;

    repeat (3) @(negedge sys_clk);
    check("rst_valid",    32'(entry_valid), 32'd0);
    check("rst_data",     32'(entry_data),  32'd0);
    check("rst_elen",     32'(entry_len),   32'd0);
    check("rst_display",  32'(display),     32'd0);
    check("rst_disp_len", 32'(disp_len),    32'd0);
    check("rst_pulses",   32'({overflow, timeout}), 32'd0);
    sys_rst_n = 1'b1;
    repeat (S + 3) @(negedge sys_clk);

    // Press latency: first edge carrying 0x1 is t, buffer updates at t+S+1.
    key_code = 4'h1;
    repeat (S + 1) @(negedge sys_clk);
    check("lat_before", 32'(disp_len), 32'd0);
    @(negedge sys_clk);
    check("lat_at",     32'(disp_len), 32'd1);
    check("lat_disp",   32'(display),  32'h0001);
    repeat (4) @(negedge sys_clk);
    key_code = 4'hF;
    repeat (S + 3) @(negedge sys_clk);
    check("single_press", 32'(display), 32'h0001);

    key(4'h5, 3);
    check("glitch_ignored", 32'(display), 32'h0001);
    key(4'h5, 6);
    check("glitch_then_ok", 32'(display),  32'h0015);
    check("glitch_len",     32'(disp_len), 32'd2);
    key(4'hA, 6);
    check("clear_disp", 32'(display),  32'h0);
    check("clear_len",  32'(disp_len), 32'd0);

    // Entry held under back-pressure, then transferred.
    key(4'h1, 6); key(4'h2, 6); key(4'h3, 6); key(4'hB, 6);
    check("four_digits", 32'(display), 32'h1230);
    e.data = 16'h1230; e.len = LW'(4);
    exp_q.push_back(e);
    key(4'hC, 6);
    check("send_valid", 32'(entry_valid), 32'd1);
    check("send_data",  32'(entry_data),  32'h1230);
    check("send_len",   32'(entry_len),   32'd4);
    repeat (20) @(negedge sys_clk);
    check("hold_valid", 32'(entry_valid), 32'd1);
    check("hold_data",  32'(entry_data),  32'h1230);
    check("hold_disp",  32'(display),     32'h1230);
    set_ready(1'b1);
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("post_xfer_valid", 32'(entry_valid), 32'd0);
    check("post_xfer_disp",  32'(display),     32'h0);
    check("post_xfer_len",   32'(disp_len),    32'd0);
    check("queue_drained",   32'(exp_q.size()), 32'd0);

    // Overflow on the fifth digit, then clear, then enter from IDLE is ignored.
    ov0 = ovf_cnt;
    key(4'h1, 6); key(4'h2, 6); key(4'h3, 6); key(4'h4, 6);
    check("no_ovf_yet", 32'(ovf_cnt - ov0), 32'd0);
    key(4'h5, 6);
    check("ovf_once",  32'(ovf_cnt - ov0), 32'd1);
    check("ovf_disp",  32'(display),  32'h1234);
    check("ovf_len",   32'(disp_len), 32'd4);
    key(4'hA, 6);
    check("star_disp", 32'(display),  32'h0);
    check("star_len",  32'(disp_len), 32'd0);
    vc0 = valid_cyc;
    key(4'hC, 6);
    check("idle_enter_ignored", 32'(valid_cyc - vc0), 32'd0);

    // With ready held high, valid lasts exactly one cycle.
    key(4'h4, 6);
    e.data = 16'h0004; e.len = LW'(1);
    exp_q.push_back(e);
    vc0 = valid_cyc;
    key(4'hC, 6);
    check("one_cycle_valid", 32'(valid_cyc - vc0), 32'd1);
    check("queue_drained2",  32'(exp_q.size()), 32'd0);

    // Inactivity in ENTRY.
    to0 = to_cnt;
    key(4'h7, 6);
`ifdef KEYPAD_TIMEOUT_EN
    repeat (T + 10) @(negedge sys_clk);
    check("timeout_once", 32'(to_cnt - to0), 32'd1);
    check("timeout_len",  32'(disp_len),     32'd0);
`else
    repeat (1000) @(negedge sys_clk);
    check("no_timeout",     32'(to_cnt - to0), 32'd0);
    check("entry_persists", 32'(disp_len),     32'd1);
`endif
    key(4'hA, 6);
    check("after_idle_len", 32'(disp_len), 32'd0);

    // Asynchronous reset while an entry waits in SEND.
    set_ready(1'b0);
    key(4'h8, 6);
    key(4'hC, 6);
    check("pre_rst_valid", 32'(entry_valid), 32'd1);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(entry_valid), 32'd0);
    check("async_rst_disp",  32'(display),     32'h0);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    set_ready(1'b1);
    repeat (S + 3) @(negedge sys_clk);
    key(4'h9, 6);
    check("fresh_disp", 32'(display),  32'h0009);
    check("fresh_len",  32'(disp_len), 32'd1);
    check("queue_final", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencer that sits downstream of the keypad scanner and turns its raw 4-bit key code (0xF = no key) into a multi-digit entry. It qualifies presses and releases, accumulates digits into a shift buffer, and handles clear (`*`) and enter (`#`). Completed entries are handed to a consumer over a valid/ready handshake, with an optional inactivity timeout.

## Interface
- `DIGITS`, 4: max digits held in the entry buffer.
- `STABLE_CYCLES`, 4000: consecutive identical samples required to accept a press or a release (one full scan period).
- `TIMEOUT_CYCLES`, 50_000_000: inactivity limit in ENTRY (only with `KEYPAD_TIMEOUT_EN`).

- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `key_code`  in  4  scanner output. 0x1–0x9 are digits, 0xB is digit 0, 0xA is `*` (clear), 0xC is `#` (enter), 0xF is none; 0xD/0xE are treated as none.
- `entry_ready`  in  1  consumer accepts the entry.
- `entry_valid`  out  1  entry available.
- `entry_data`  out  4*DIGITS  latched entry, newest digit in bits [3:0], zero-extended.
- `entry_len`  out  $clog2(DIGITS+1)  number of digits in `entry_data`.
- `display`  out  4*DIGITS  live buffer contents, for the 7-segment driver.
- `disp_len`  out  $clog2(DIGITS+1)  live digit count.
- `overflow`  out  1  one-cycle pulse when a digit is dropped because the buffer is full.
- `timeout`  out  1  one-cycle pulse when the entry is cleared by the timeout.

## Operation
- The input is registered once (`k_q`). All following logic uses `k_q`.
- Press qualifier FSM:
  - WAIT_PRESS: a stability counter restarts whenever `k_q` changes. When a non-0xF value has been held STABLE_CYCLES samples, emit a single-cycle internal `press` carrying that code, then go to WAIT_RELEASE.
  - WAIT_RELEASE: when `k_q` has been 0xF for STABLE_CYCLES samples, go to WAIT_PRESS.
  - A key held indefinitely yields exactly one press. A code change while held does not produce a new press.
- Entry FSM:
  - IDLE:
    - digit press: buffer = digit, len = 1, go to ENTRY.
    - `*` and `#` are ignored.
  - ENTRY:
    - digit press with len < DIGITS: buffer = {buffer[4*DIGITS-5:0], digit}, len += 1.
    - digit press with len == DIGITS: digit dropped, `overflow` pulses.
    - `*`: buffer = 0, len = 0, go to IDLE.
    - `#`: `entry_data` = buffer, `entry_len` = len, `entry_valid` = 1, go to SEND.
  - SEND:
    - Presses are qualified but discarded.
    - When `entry_valid` and `entry_ready` are both 1 on a clock edge: `entry_valid` = 0, buffer = 0, len = 0, go to IDLE.
- Handshake rules:
  - `entry_valid` never drops without a transfer.
  - `entry_data` and `entry_len` are stable while valid.
  - `entry_ready` is don't-care while `entry_valid` = 0.
- `display` and `disp_len` mirror the buffer and len in every state. In SEND they still show the submitted entry until the transfer.

## Timing
- Reset values:
  - Both FSMs: WAIT_PRESS / IDLE.
  - Counters 0, `k_q` = 0xF.
  - `entry_valid`, `overflow`, `timeout` = 0.
  - `entry_data`, `display` = 0; `entry_len`, `disp_len` = 0.
- Reset mid-SEND drops the pending entry.
- Latency: a key first presented on `key_code` at edge t produces `press` in cycle t+STABLE_CYCLES. `display` and `disp_len` update at edge t+STABLE_CYCLES+1.
- For `#`, `entry_valid` rises at that same edge.
- With `entry_ready` held at 1, `entry_valid` is high for exactly 1 cycle.
- `overflow` and `timeout` are registered one-cycle pulses, coincident with the buffer update.
- A press and a handshake completing in the same cycle: the press is discarded, because the FSM is still in SEND during that cycle.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - In ENTRY, an idle counter clears to 0 on entry to ENTRY and on every accepted press.
  - When the counter reaches TIMEOUT_CYCLES-1: buffer = 0, len = 0, go to IDLE, `timeout` pulses.
  - The counter is inactive in IDLE and SEND.
- `KEYPAD_TIMEOUT_EN` undefined: no counter is built, `timeout` is tied 0, and ENTRY persists indefinitely.

## Test plan
Benches use STABLE_CYCLES=4, DIGITS=4, TIMEOUT_CYCLES=100.
- Reset, then key 0x1 for 10 cycles, then 0xF → `disp_len` 0→1 exactly 5 edges after 0x1 appears, `display`=0x0001, one press only.
- Glitch: 0x5 for 3 cycles, then 0xF → no change to `display`. Then 0x5 for 6 cycles → accepted.
- Keys 1,2,3,B then `#`, with `entry_ready`=0 for 20 cycles then 1 → `entry_valid` held high with `entry_data`=0x1230 and `entry_len`=4; cleared and back to IDLE the cycle after the transfer.
- Keys 1,2,3,4,5 → `overflow` pulses once on the 5th key, `display` stays 0x1234. Then `*` → `display`=0, `disp_len`=0. Then `#` → no `entry_valid`.
- `KEYPAD_TIMEOUT_EN`: key 7, then idle 100 cycles → `timeout` pulses once, `disp_len`=0. Without the macro: `disp_len` remains 1 after 1000 cycles.
- Assert `sys_rst_n` low during SEND → `entry_valid`=0 immediately (asynchronous). After release, key 9 is accepted as a fresh entry, `display`=0x0009.
